// File: rtl/bshift_pkg.sv
// Shared types for the pipelined barrel shifter: operation encoding and direction constant.
package bshift_pkg;

   typedef enum logic [1:0] {
      OP_LOGICAL = 2'd0,
      OP_ARITH   = 2'd1,
      OP_ROTATE  = 2'd2,
      OP_RSVD    = 2'd3
   } shift_op_t;

   localparam logic SHIFT_DIR_LEFT = 1'b1;

endpackage

// File: rtl/pipelined_barrel_shifter_mux2to1_n.sv
// N-bit two-way selector used by every shifter stage (sel=1 picks in1).
module mux2to1_n #(
   parameter int N = 8
) (
   input  logic [N-1:0] in0,
   input  logic [N-1:0] in1,
   input  logic         sel,
   output logic [N-1:0] y
);

   assign y = sel ? in1 : in0;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Log-depth pipelined barrel shifter: stage k shifts by 2^k, one global stall enable.
// Optional macro BSHIFT_ROTATE_EN adds rotate; without it ROTATE behaves as LOGICAL.
module pipelined_barrel_shifter
   import bshift_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic               in_dir,
   input  logic [1:0]         in_op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data
);

   logic en;

   // Fixed-distance shift for one stage; arithmetic right relies on the msb
   // already being the original sign, since earlier stages sign-filled it.
   function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                 input logic dir,
                                                 input shift_op_t op,
                                                 input int unsigned amt);
      logic [WIDTH-1:0] r;
      r = (dir == SHIFT_DIR_LEFT) ? (d << amt) : (d >> amt);
      if (op == OP_ARITH && dir != SHIFT_DIR_LEFT)
         r = $signed(d) >>> amt;
`ifdef BSHIFT_ROTATE_EN
      if (op == OP_ROTATE)
         r = (dir == SHIFT_DIR_LEFT) ? ((d << amt) | (d >> (WIDTH - amt)))
                                     : ((d >> amt) | (d << (WIDTH - amt)));
`endif
      return r;
   endfunction

   assign en       = !(out_valid && !out_ready);
   assign in_ready = en;

   for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
      logic [WIDTH-1:0]   d_in, d_shift, d_next;
      logic               v_in, dir_in;
      shift_op_t          op_in;
      logic [SHAMT_W-1:0] sh_in;
      logic [WIDTH-1:0]   data_p;
      logic               vld_p;

      if (k == 0) begin : g_src
         assign d_in   = in_data;
         assign v_in   = in_valid;
         assign dir_in = in_dir;
         assign op_in  = shift_op_t'(in_op);
         assign sh_in  = in_shamt;
      end else begin : g_src
         assign d_in   = g_stage[k-1].data_p;
         assign v_in   = g_stage[k-1].vld_p;
         assign dir_in = g_stage[k-1].g_carry.dir_p;
         assign op_in  = g_stage[k-1].g_carry.op_p;
         assign sh_in  = g_stage[k-1].g_carry.shamt_p;
      end

      assign d_shift = shift_by(d_in, dir_in, op_in, 32'd1 << k);

      // Current shamt bit always sits at position 0; carried copy is pre-shifted.
      mux2to1_n #(.N(WIDTH)) u_sel (
         .in0 (d_in),
         .in1 (d_shift),
         .sel (sh_in[0]),
         .y   (d_next)
      );

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_p  <= 1'b0;
            data_p <= '0;
         end else if (en) begin
            vld_p  <= v_in;
            data_p <= d_next;
         end
      end

      if (k < SHAMT_W - 1) begin : g_carry
         logic               dir_p;
         shift_op_t          op_p;
         logic [SHAMT_W-1:0] shamt_p;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               dir_p   <= 1'b0;
               op_p    <= OP_LOGICAL;
               shamt_p <= '0;
            end else if (en) begin
               dir_p   <= dir_in;
               op_p    <= op_in;
               shamt_p <= sh_in >> 1;
            end
         end
      end
   end

   assign out_valid = g_stage[SHAMT_W-1].vld_p;
   assign out_data  = g_stage[SHAMT_W-1].data_p;

endmodule

// File: doc/pipelined_barrel_shifter.md
PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 Parameter WIDTH, default 8, data width; SHALL be a power of two, 4..64.
REQ-002 Parameter SHAMT_W, default $clog2(WIDTH), shift-amount width; derived, not overridden.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  input beat present.
REQ-006 in_ready  output  1  shifter accepts beat this cycle.
REQ-007 in_data  input  WIDTH  operand.
REQ-008 in_shamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
REQ-009 in_dir  input  1  1 = left shift, 0 = right shift.
REQ-010 in_op  input  2  shift_op_t: LOGICAL=0, ARITH=1, ROTATE=2, 3 reserved.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_data  output  WIDTH  shifted result.

Function
REQ-014 Datapath SHALL be SHAMT_W registered stages; stage k conditionally shifts by 2^k under bit k of shamt.
REQ-015 Latency SHALL be exactly SHAMT_W cycles from accepted beat to out_valid with no stall.
REQ-016 Global advance enable en = !(out_valid && !out_ready); all stages, valid bits included, SHALL load only when en=1.
REQ-017 in_ready SHALL equal en; a beat transfers when in_valid && in_ready.
REQ-018 When en=1 and no beat transfers, stage 0 SHALL load valid=0 (bubble); bubbles are not collapsed.
REQ-019 Throughput SHALL be one beat per cycle while out_ready=1.
REQ-020 Each stage SHALL carry dir, op and remaining shamt bits alongside data.
REQ-021 LOGICAL: vacated bits SHALL fill with 0 in both directions.
REQ-022 ARITH right: vacated bits SHALL fill with original in_data[WIDTH-1]; ARITH left SHALL equal LOGICAL left.
REQ-023 ROTATE: bits shifted out SHALL re-enter at the opposite end.
REQ-024 op=3 SHALL behave as LOGICAL.
REQ-025 shamt=0 SHALL pass data unchanged for every op and dir.
REQ-026 out_data and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 out_data SHALL be don't-care when out_valid=0 but SHALL be driven from last stage register (no X on reset).

Reset
REQ-028 rst=1 SHALL immediately clear all stage valid bits; out_valid=0, out_data=0, in_ready=1 after deassertion.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; none emerge afterwards.
REQ-030 Stage data registers SHALL reset to 0.

Configuration
REQ-031 Macro BSHIFT_ROTATE_EN defined: ROTATE per REQ-023.
REQ-032 Macro BSHIFT_ROTATE_EN undefined: rotate logic omitted, op=ROTATE SHALL behave as LOGICAL.

Structure
REQ-033 Package bshift_pkg SHALL hold typedef enum logic [1:0] shift_op_t and localparam SHIFT_DIR_LEFT=1'b1.
REQ-034 Per-bit stage selection SHALL use sub-module mux2to1_n (parameter N, in==1 selects in1).
REQ-035 Stage registers SHALL be built with a generate loop over SHAMT_W.

Verification (WIDTH=8, latency 3)
REQ-036 in_data=8'hB4, shamt=2, dir=0, op=ARITH -> out_data=8'hED after 3 cycles.
REQ-037 in_data=8'hB4, shamt=3, dir=1, op=ROTATE -> 8'hA5 with macro; 8'hA0 without.
REQ-038 Back-to-back 8 beats, out_ready=1 -> 8 results on consecutive cycles, order preserved.
REQ-039 out_ready=0 for 5 cycles with pipeline full -> in_ready=0, out_data stable, no beat lost or duplicated.
REQ-040 rst pulsed with 2 beats in flight -> out_valid=0 immediately and stays 0 until a new beat is accepted.
REQ-041 shamt=0, all ops and dirs, in_data=8'h5A -> out_data=8'h5A.
